// File: rtl/ge_pkg.sv
// Shared types and default sizes for the GF(2) elimination row feeder.
// Optional watchdog is enabled with GE_FEED_TIMEOUT_EN.
package ge_pkg;

  localparam int GE_DAT_W   = 4;
  localparam int GE_TIMEOUT = 64;

  typedef enum logic [1:0] {
    LOAD,
    FEED,
    WAIT,
    RESULT
  } ge_state_e;

endpackage

// File: rtl/ge_row_buf.sv
// DAT_W x DAT_W row store: one write port, one combinational read port.
// Contents are never reset; every matrix overwrites all rows.
module ge_row_buf
  import ge_pkg::*;
#(
  parameter int DAT_W = GE_DAT_W,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DAT_W-1:0] wr_row,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DAT_W-1:0] rd_row
);

  logic [DAT_W-1:0] mem_q [DAT_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_row;
    end
  end

  assign rd_row = mem_q[rd_idx];

endmodule

// File: rtl/ge_row_feeder.sv
// Loads one binary matrix, streams it into the systolic GE array, returns rank.
// Define GE_FEED_TIMEOUT_EN to add the WAIT watchdog and res_timeout port.
module ge_row_feeder
  import ge_pkg::*;
#(
  parameter int DAT_W   = GE_DAT_W,
  parameter int TIMEOUT = GE_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DAT_W-1:0] in_row,
  output logic             sa_start,
  output logic [DAT_W-1:0] sa_data,
  input  logic             sa_finish,
  input  logic             sa_full_rank,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_full_rank,
`ifdef GE_FEED_TIMEOUT_EN
  output logic             res_timeout,
`endif
  output logic             busy
);

  localparam int IDX_W = (DAT_W > 1) ? $clog2(DAT_W) : 1;
  localparam int CNT_W = $clog2(DAT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DAT_W - 1);
  localparam logic [IDX_W-1:0] LAST_FEED = IDX_W'(DAT_W - 1);

  ge_state_e        state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0] feed_cnt_q, feed_cnt_d;
  logic             sa_start_q, sa_start_d;
  logic [DAT_W-1:0] sa_data_q, sa_data_d;
  logic             full_rank_q, full_rank_d;

  logic             wr_en;
  logic [IDX_W-1:0] rd_idx;
  logic [DAT_W-1:0] rd_row;
  logic [DAT_W-1:0] first_row;

`ifdef GE_FEED_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT + 1);
  localparam logic [WT_W-1:0] WT_LIM = WT_W'(TIMEOUT);
  logic [WT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  ge_row_buf #(
    .DAT_W (DAT_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (row_cnt_q[IDX_W-1:0]),
    .wr_row (in_row),
    .rd_idx (rd_idx),
    .rd_row (rd_row)
  );

  // With a single row, row 0 is the one being written this cycle.
  assign first_row = (DAT_W == 1) ? in_row : rd_row;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    sa_start_d  = 1'b0;
    sa_data_d   = '0;
    full_rank_d = full_rank_q;
    wr_en       = 1'b0;
    rd_idx      = '0;
`ifdef GE_FEED_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (row_cnt_q == LAST_ROW) begin
            state_d    = FEED;
            row_cnt_d  = '0;
            feed_cnt_d = '0;
            sa_start_d = 1'b1;
            sa_data_d  = first_row;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      FEED: begin
        if (feed_cnt_q == LAST_FEED) begin
          state_d = WAIT;
`ifdef GE_FEED_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          feed_cnt_d = feed_cnt_q + 1'b1;
          rd_idx     = feed_cnt_q + 1'b1;
          sa_data_d  = rd_row;
        end
      end
      WAIT: begin
        if (sa_finish) begin
          state_d     = RESULT;
          full_rank_d = sa_full_rank;
`ifdef GE_FEED_TIMEOUT_EN
          timeout_d   = 1'b0;
        end else if (wait_cnt_q == WT_LIM) begin
          state_d     = RESULT;
          full_rank_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = LOAD;
`ifdef GE_FEED_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= LOAD;
      row_cnt_q   <= '0;
      feed_cnt_q  <= '0;
      sa_start_q  <= 1'b0;
      sa_data_q   <= '0;
      full_rank_q <= 1'b0;
`ifdef GE_FEED_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      sa_start_q  <= sa_start_d;
      sa_data_q   <= sa_data_d;
      full_rank_q <= full_rank_d;
`ifdef GE_FEED_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign in_ready      = (state_q == LOAD);
  assign busy          = (state_q != LOAD);
  assign res_valid     = (state_q == RESULT);
  assign sa_start      = sa_start_q;
  assign sa_data       = sa_data_q;
  assign res_full_rank = full_rank_q;
`ifdef GE_FEED_TIMEOUT_EN
  assign res_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_ge_row_feeder.sv
// Randomized bench for ge_row_feeder with a behavioural GF(2) array model.
// Watchdog scenarios run when GE_FEED_TIMEOUT_EN is defined.
module tb_ge_row_feeder;

  localparam int DW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_row;
  logic          sa_start;
  logic [DW-1:0] sa_data;
  logic          sa_finish;
  logic          sa_full_rank;
  logic          res_valid;
  logic          res_ready;
  logic          res_full_rank;
  logic          busy;
`ifdef GE_FEED_TIMEOUT_EN
  logic          res_timeout;
`endif

  logic model_fin;
  logic stray_fin;
  assign sa_finish = model_fin | stray_fin;

  ge_row_feeder #(
    .DAT_W   (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_row        (in_row),
    .sa_start      (sa_start),
    .sa_data       (sa_data),
    .sa_finish     (sa_finish),
    .sa_full_rank  (sa_full_rank),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_full_rank (res_full_rank),
`ifdef GE_FEED_TIMEOUT_EN
    .res_timeout   (res_timeout),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  logic [DW-1:0] ld_rows [DW];
  logic [DW-1:0] cap [DW];
  int cap_n      = 0;
  int cap_left   = 0;
  int fin_cd     = 0;
  int fin_c      = -1;
  int start_c    = -1;
  int start_cnt  = 0;
  int stray_data = 0;
  bit arr_en     = 1'b1;
  int arr_lat    = 3;

  function automatic int rank_of(input logic [DW-1:0] r [DW]);
    logic [DW-1:0] m [DW];
    logic [DW-1:0] t;
    int rk;
    int p;
    m  = r;
    rk = 0;
    for (int col = DW - 1; col >= 0; col--) begin
      p = -1;
      for (int i = rk; i < DW; i++)
        if (p < 0 && m[i][col]) p = i;
      if (p >= 0) begin
        t     = m[p];
        m[p]  = m[rk];
        m[rk] = t;
        for (int i = 0; i < DW; i++)
          if (i != rk && m[i][col]) m[i] = m[i] ^ m[rk];
        rk++;
      end
    end
    return rk;
  endfunction

  function automatic bit caps_ok();
    if (cap_n != DW) return 1'b0;
    for (int i = 0; i < DW; i++)
      if (cap[i] !== ld_rows[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Array model: captures DW rows after start, answers after arr_lat cycles.
  always @(negedge clk) begin
    model_fin = 1'b0;
    if (rst_b) begin
      cap_left = 0;
      fin_cd   = 0;
    end else begin
      if (fin_cd > 0) begin
        fin_cd--;
        if (fin_cd == 0) begin
          model_fin    = 1'b1;
          sa_full_rank = (rank_of(cap) == DW);
          fin_c        = cyc;
        end
      end
      if (sa_start) begin
        start_cnt++;
        start_c  = cyc;
        cap[0]   = sa_data;
        cap_n    = 1;
        cap_left = DW - 1;
      end else if (cap_left > 0) begin
        cap[cap_n] = sa_data;
        cap_n++;
        cap_left--;
        if (cap_left == 0 && arr_en) fin_cd = arr_lat;
      end else if (sa_data !== '0) begin
        stray_data++;
      end
    end
  end

  task automatic do_reset();
    rst_b     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    stray_fin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  // gap_mode: 0 none, 1 random, 2 fixed 1,0,0,1,1,0,1
  task automatic load_rows(input int gap_mode, output int last_c);
    bit [6:0] pat = 7'b1001101;
    int k = 0;
    int i = 0;
    bit v;
    last_c = -1;
    while (k < DW && i < 200) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = pat[6 - (i % 7)];
      endcase
      in_valid = v;
      in_row   = v ? ld_rows[k] : DW'($urandom);
      @(posedge clk);
      #1;
      if (v) begin
        last_c = cyc - 1;
        k++;
      end
      i++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, input bit junk,
                             output int rv_c, output bit ok);
    ok   = 1'b0;
    rv_c = -1;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        ok   = 1'b1;
        rv_c = cyc;
        break;
      end
      in_valid = junk;
      in_row   = DW'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    n_tests++;
    if (sa_start !== 1'b0 || sa_data !== '0) begin
      n_fail++;
      $display("FAIL reset_sa: start=%b data=%h want 0/0", sa_start, sa_data);
    end
    n_tests++;
    if (res_valid !== 1'b0 || res_full_rank !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_res: valid=%b rank=%b want 0/0", res_valid, res_full_rank);
    end
`ifdef GE_FEED_TIMEOUT_EN
    n_tests++;
    if (res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b want 0", res_timeout);
    end
`endif
  endtask

  task automatic test_identity();
    int last_c, rv_c, s0, d0;
    bit ok;
    ld_rows = '{4'h8, 4'h4, 4'h2, 4'h1};
    arr_lat = 3;
    s0 = start_cnt;
    d0 = stray_data;
    load_rows(0, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || start_cnt - s0 != 1 || start_c != last_c + 1) begin
      n_fail++;
      $display("FAIL ident_start: ok=%b starts=%0d start_c=%0d want 1 at %0d",
               ok, start_cnt - s0, start_c, last_c + 1);
    end
    n_tests++;
    if (!caps_ok()) begin
      n_fail++;
      $display("FAIL ident_rows: got %h %h %h %h want 8 4 2 1",
               cap[0], cap[1], cap[2], cap[3]);
    end
    n_tests++;
    if (rv_c != fin_c + 1 || res_full_rank !== 1'b1) begin
      n_fail++;
      $display("FAIL ident_result: rv_c=%0d rank=%b want %0d/1",
               rv_c, res_full_rank, fin_c + 1);
    end
    handshake();
    n_tests++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || stray_data != d0) begin
      n_fail++;
      $display("FAIL ident_after: in_ready=%b res_valid=%b stray=%0d want 1/0/0",
               in_ready, res_valid, stray_data - d0);
    end
    if (!ok) do_reset();
  endtask

  task automatic test_singular();
    int last_c, rv_c;
    bit ok;
    ld_rows = '{4'hC, 4'hC, 4'h3, 4'h1};
    arr_lat = 2;
    load_rows(0, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || !caps_ok() || res_full_rank !== 1'b0) begin
      n_fail++;
      $display("FAIL singular: ok=%b rows_ok=%b rank=%b want 1/1/0",
               ok, caps_ok(), res_full_rank);
    end
    handshake();
    if (!ok) do_reset();
  endtask

  task automatic test_gaps();
    int last_c, rv_c, s0;
    bit ok;
    ld_rows = '{4'h5, 4'hA, 4'h3, 4'hE};
    arr_lat = 4;
    s0 = start_cnt;
    load_rows(2, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || start_cnt - s0 != 1 || start_c != last_c + 1) begin
      n_fail++;
      $display("FAIL gaps_start: starts=%0d start_c=%0d want 1 at %0d",
               start_cnt - s0, start_c, last_c + 1);
    end
    n_tests++;
    if (!caps_ok()) begin
      n_fail++;
      $display("FAIL gaps_rows: got %h %h %h %h want 5 a 3 e",
               cap[0], cap[1], cap[2], cap[3]);
    end
    n_tests++;
    if (res_full_rank !== (rank_of(ld_rows) == DW)) begin
      n_fail++;
      $display("FAIL gaps_rank: got %b want %b",
               res_full_rank, rank_of(ld_rows) == DW);
    end
    handshake();
    if (!ok) do_reset();
  endtask

  task automatic test_res_hold();
    int last_c, rv_c, bad;
    bit ok;
    ld_rows = '{4'h1, 4'h2, 4'h4, 4'h8};
    arr_lat = 1;
    load_rows(0, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_full_rank !== 1'b1 ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: ok=%b bad_cycles=%0d want 1/0", ok, bad);
    end
    n_tests++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_valid: got %b want 1", res_valid);
    end
    handshake();
    n_tests++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: in_ready=%b res_valid=%b want 1/0",
               in_ready, res_valid);
    end
    if (!ok) do_reset();
  endtask

  task automatic test_ignore();
    int last_c, rv_c;
    bit ok;
    stray_fin = 1'b1;
    @(posedge clk);
    #1;
    stray_fin = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_fin_load: res_valid=%b in_ready=%b want 0/1",
               res_valid, in_ready);
    end
    ld_rows = '{4'h9, 4'h6, 4'h3, 4'h1};
    arr_lat = 5;
    load_rows(0, last_c);
    stray_fin = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    stray_fin = 1'b0;
    wait_result(100, 1'b1, rv_c, ok);
    n_tests++;
    if (!ok || rv_c != fin_c + 1 || !caps_ok()) begin
      n_fail++;
      $display("FAIL ignore_fin_feed: rv_c=%0d want %0d rows_ok=%b",
               rv_c, fin_c + 1, caps_ok());
    end
    handshake();
    if (!ok) do_reset();
    ld_rows = '{4'h7, 4'hB, 4'hD, 4'hE};
    load_rows(0, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || !caps_ok() || start_c != last_c + 1) begin
      n_fail++;
      $display("FAIL ignore_valid: rows %h %h %h %h want 7 b d e, start_c=%0d want %0d",
               cap[0], cap[1], cap[2], cap[3], start_c, last_c + 1);
    end
    handshake();
    if (!ok) do_reset();
  endtask

  task automatic test_reset_mid_feed();
    int last_c, rv_c;
    bit ok;
    ld_rows = '{4'hF, 4'h0, 4'hF, 4'h0};
    load_rows(0, last_c);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    n_tests++;
    if (sa_data !== '0 || sa_start !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_out: data=%h start=%b in_ready=%b want 0/0/1",
               sa_data, sa_start, in_ready);
    end
    ld_rows = '{4'h3, 4'h6, 4'hC, 4'h9};
    arr_lat = 2;
    load_rows(1, last_c);
    wait_result(100, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || !caps_ok() || start_c != last_c + 1 ||
        res_full_rank !== (rank_of(ld_rows) == DW)) begin
      n_fail++;
      $display("FAIL midrst_reload: ok=%b rows_ok=%b rank=%b want 1/1/%b",
               ok, caps_ok(), res_full_rank, rank_of(ld_rows) == DW);
    end
    handshake();
    if (!ok) do_reset();
  endtask

  task automatic test_random();
    int last_c, rv_c, s0, d0;
    bit ok, junk, exp_full;
    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < DW; r++) ld_rows[r] = DW'($urandom);
      if (n % 4 == 0) ld_rows = '{4'h8, 4'h4 | DW'($urandom_range(0, 3)), 4'h2, 4'h1};
      exp_full = (rank_of(ld_rows) == DW);
      arr_lat  = $urandom_range(1, 6);
      junk     = $urandom_range(0, 1);
      s0 = start_cnt;
      d0 = stray_data;
      load_rows(1, last_c);
      wait_result(100, junk, rv_c, ok);
      n_tests++;
      if (!ok || start_cnt - s0 != 1 || start_c != last_c + 1 || !caps_ok()) begin
        n_fail++;
        $display("FAIL rand_feed[%0d]: ok=%b starts=%0d start_c=%0d want %0d rows_ok=%b",
                 n, ok, start_cnt - s0, start_c, last_c + 1, caps_ok());
      end
      n_tests++;
      if (rv_c != fin_c + 1 || res_full_rank !== exp_full) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: rv_c=%0d rank=%b want %0d/%b",
                 n, rv_c, res_full_rank, fin_c + 1, exp_full);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      handshake();
      n_tests++;
      if (in_ready !== 1'b1 || stray_data != d0) begin
        n_fail++;
        $display("FAIL rand_after[%0d]: in_ready=%b stray=%0d want 1/0",
                 n, in_ready, stray_data - d0);
      end
      if (!ok) do_reset();
    end
  endtask

`ifdef GE_FEED_TIMEOUT_EN
  task automatic test_timeout();
    int last_c, rv_c, w;
    bit ok;
    ld_rows = '{4'h8, 4'h4, 4'h2, 4'h1};
    arr_en  = 1'b0;
    load_rows(0, last_c);
    w = last_c + 1 + DW;
    wait_result(60, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || rv_c != w + TMO + 1) begin
      n_fail++;
      $display("FAIL tmo_time: ok=%b rv_c=%0d want %0d", ok, rv_c, w + TMO + 1);
    end
    n_tests++;
    if (res_timeout !== 1'b1 || res_full_rank !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_flags: timeout=%b rank=%b want 1/0",
               res_timeout, res_full_rank);
    end
    handshake();
    n_tests++;
    if (res_timeout !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_clear: timeout=%b in_ready=%b want 0/1",
               res_timeout, in_ready);
    end
    if (!ok) do_reset();
    arr_en  = 1'b1;
    arr_lat = TMO + 1;
    load_rows(0, last_c);
    w = last_c + 1 + DW;
    wait_result(60, 1'b0, rv_c, ok);
    n_tests++;
    if (!ok || rv_c != w + TMO + 1 || res_timeout !== 1'b0 ||
        res_full_rank !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_priority: rv_c=%0d timeout=%b rank=%b want %0d/0/1",
               rv_c, res_timeout, res_full_rank, w + TMO + 1);
    end
    handshake();
    if (!ok) do_reset();
  endtask
`endif

  initial begin
    rst_b        = 1'b1;
    in_valid     = 1'b0;
    in_row       = '0;
    res_ready    = 1'b0;
    stray_fin    = 1'b0;
    model_fin    = 1'b0;
    sa_full_rank = 1'b0;
    test_reset();
    test_identity();
    test_singular();
    test_gaps();
    test_res_hold();
    test_ignore();
    test_reset_mid_feed();
`ifdef GE_FEED_TIMEOUT_EN
    test_identity();
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
